// File: rtl/mpu_store_unit.sv
// Store engine: snapshots one matrix register and streams its valid m x n
// elements row-major over a valid/ready handshake, then pulses done.
module mpu_store_unit #(
   parameter int FP = 32,
   parameter int M = 3,
   parameter int N = 3,
   parameter int MATRIX_REGISTERS = 8,
   localparam int AW = $clog2(MATRIX_REGISTERS),
   localparam int MW = $clog2(M) + 1,
   localparam int NW = $clog2(N) + 1,
   localparam int RW = $clog2(M),
   localparam int CW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            store_req_i,
   input  logic [AW-1:0]   store_addr_i,
   output logic            store_ready_o,
   output logic            reg_rd_en_o,
   output logic [AW-1:0]   reg_rd_addr_o,
   input  logic [M*N*FP-1:0] reg_rd_matrix_i,
   input  logic [MW-1:0]   reg_rd_m_i,
   input  logic [NW-1:0]   reg_rd_n_i,
   output logic            elem_valid_o,
   input  logic            elem_ready_i,
   output logic [FP-1:0]   elem_data_o,
   output logic [RW-1:0]   elem_row_o,
   output logic [CW-1:0]   elem_col_o,
   output logic            elem_last_o,
   output logic            store_done_o,
   output logic            store_err_o
);

   localparam int IW = $clog2(M * N);

   typedef enum logic [1:0] {
      STORE_IDLE,
      STORE_REQUEST,
      STORE_MATRIX
   } store_state_e;

   store_state_e        state_reg, state_next;
   logic [AW-1:0]       addr_reg, addr_next;
   logic [M*N*FP-1:0]   buf_reg;
   logic                buf_load;
   logic [MW-1:0]       m_reg, m_next;
   logic [NW-1:0]       n_reg, n_next;
   logic [RW-1:0]       row_reg, row_next;
   logic [CW-1:0]       col_reg, col_next;
   logic                done_reg, done_next;
   logic                err_reg, err_next;

   logic                dims_bad;
   logic                col_end;
   logic                last_elem;
   logic [IW-1:0]       elem_idx;

   assign dims_bad  = (reg_rd_m_i == '0) || (reg_rd_n_i == '0) ||
                      (reg_rd_m_i > MW'(M)) || (reg_rd_n_i > NW'(N));
   assign col_end   = (NW'(col_reg) == n_reg - NW'(1));
   assign last_elem = col_end && (MW'(row_reg) == m_reg - MW'(1));
   // Buffer keeps the full M x N layout, so the stride is always N.
   assign elem_idx  = IW'(row_reg) * IW'(N) + IW'(col_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= STORE_IDLE;
         addr_reg  <= '0;
         buf_reg   <= '0;
         m_reg     <= '0;
         n_reg     <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         if (buf_load) begin
            buf_reg <= reg_rd_matrix_i;
         end
         m_reg     <= m_next;
         n_reg     <= n_next;
         row_reg   <= row_next;
         col_reg   <= col_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      buf_load   = 1'b0;
      m_next     = m_reg;
      n_next     = n_reg;
      row_next   = row_reg;
      col_next   = col_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         STORE_IDLE: begin
            if (store_req_i) begin
               addr_next  = store_addr_i;
               state_next = STORE_REQUEST;
            end
         end
         STORE_REQUEST: begin
            buf_load = 1'b1;
            m_next   = reg_rd_m_i;
            n_next   = reg_rd_n_i;
            if (dims_bad) begin
               done_next  = 1'b1;
               err_next   = 1'b1;
               state_next = STORE_IDLE;
            end else begin
               row_next   = '0;
               col_next   = '0;
               state_next = STORE_MATRIX;
            end
         end
         STORE_MATRIX: begin
            if (elem_ready_i) begin
               if (last_elem) begin
                  done_next  = 1'b1;
                  state_next = STORE_IDLE;
               end else if (col_end) begin
                  col_next = '0;
                  row_next = row_reg + RW'(1);
               end else begin
                  col_next = col_reg + CW'(1);
               end
            end
         end
         default: state_next = STORE_IDLE;
      endcase
   end

   // Element outputs are driven straight from state so an async reset drops them at once.
   assign store_ready_o = (state_reg == STORE_IDLE);
   assign reg_rd_en_o   = (state_reg == STORE_REQUEST);
   assign reg_rd_addr_o = addr_reg;
   assign elem_valid_o  = (state_reg == STORE_MATRIX);
   assign elem_data_o   = buf_reg[elem_idx*FP +: FP];
   assign elem_row_o    = row_reg;
   assign elem_col_o    = col_reg;
   assign elem_last_o   = (state_reg == STORE_MATRIX) && last_elem;
   assign store_done_o  = done_reg;
   assign store_err_o   = err_reg;

endmodule

// File: tb/tb_mpu_store_unit.sv
// Directed bench for mpu_store_unit: full, backpressured, partial, illegal,
// reset-abort, ignored-request and 1x1 stores against a small register file model.
module tb_mpu_store_unit;

   localparam int FP = 32;
   localparam int M = 3;
   localparam int N = 3;

   logic                 clk;
   logic                 rst_n;
   logic                 store_req_i;
   logic [2:0]           store_addr_i;
   logic                 store_ready_o;
   logic                 reg_rd_en_o;
   logic [2:0]           reg_rd_addr_o;
   logic [M*N*FP-1:0]    reg_rd_matrix_i;
   logic [2:0]           reg_rd_m_i;
   logic [2:0]           reg_rd_n_i;
   logic                 elem_valid_o;
   logic                 elem_ready_i;
   logic [FP-1:0]        elem_data_o;
   logic [1:0]           elem_row_o;
   logic [1:0]           elem_col_o;
   logic                 elem_last_o;
   logic                 store_done_o;
   logic                 store_err_o;

   logic [M*N*FP-1:0]    rf_data [8];
   logic [2:0]           rf_m [8];
   logic [2:0]           rf_n [8];
   logic [31:0]          fl [10];

   int vectors;
   int miscompares;

   mpu_store_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .store_req_i     (store_req_i),
      .store_addr_i    (store_addr_i),
      .store_ready_o   (store_ready_o),
      .reg_rd_en_o     (reg_rd_en_o),
      .reg_rd_addr_o   (reg_rd_addr_o),
      .reg_rd_matrix_i (reg_rd_matrix_i),
      .reg_rd_m_i      (reg_rd_m_i),
      .reg_rd_n_i      (reg_rd_n_i),
      .elem_valid_o    (elem_valid_o),
      .elem_ready_i    (elem_ready_i),
      .elem_data_o     (elem_data_o),
      .elem_row_o      (elem_row_o),
      .elem_col_o      (elem_col_o),
      .elem_last_o     (elem_last_o),
      .store_done_o    (store_done_o),
      .store_err_o     (store_err_o)
   );

   // Combinational register file read
   assign reg_rd_matrix_i = rf_data[reg_rd_addr_o];
   assign reg_rd_m_i      = rf_m[reg_rd_addr_o];
   assign reg_rd_n_i      = rf_n[reg_rd_addr_o];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Request at E0, check the read cycle, stream with ready high, check done.
   // The register is overwritten during the stream to prove the local snapshot.
   task automatic run_store(input string tag, input int addr);
      logic [M*N*FP-1:0] snap;
      int cnt;
      int ncol;
      int idx;
      snap = rf_data[addr];
      cnt  = int'(rf_m[addr]) * int'(rf_n[addr]);
      ncol = int'(rf_n[addr]);
      elem_ready_i = 1'b1;
      store_req_i  = 1'b1;
      store_addr_i = 3'(addr);
      tick();
      store_req_i  = 1'b0;
      check({tag, "_rd_en"}, 64'(reg_rd_en_o), 64'd1);
      check({tag, "_rd_addr"}, 64'(reg_rd_addr_o), 64'(addr));
      check({tag, "_c1_valid"}, 64'(elem_valid_o), 64'd0);
      tick();
      rf_data[addr] = ~snap;
      for (int k = 0; k < cnt; k++) begin
         idx = (k / ncol) * N + (k % ncol);
         check({tag, "_valid"}, 64'(elem_valid_o), 64'd1);
         check({tag, "_data"}, 64'(elem_data_o), 64'(snap[idx*FP +: FP]));
         check({tag, "_row"}, 64'(elem_row_o), 64'(k / ncol));
         check({tag, "_col"}, 64'(elem_col_o), 64'(k % ncol));
         check({tag, "_last"}, 64'(elem_last_o), 64'(k == cnt - 1));
         check({tag, "_early_done"}, 64'(store_done_o), 64'd0);
         $display("%s elem %0d r%0d c%0d data=%h last=%0b", tag, k, elem_row_o, elem_col_o,
                  elem_data_o, elem_last_o);
         tick();
      end
      rf_data[addr] = snap;
      check({tag, "_done"}, 64'(store_done_o), 64'd1);
      check({tag, "_err"}, 64'(store_err_o), 64'd0);
      check({tag, "_ready"}, 64'(store_ready_o), 64'd1);
      check({tag, "_end_valid"}, 64'(elem_valid_o), 64'd0);
      tick();
      check({tag, "_done_1cyc"}, 64'(store_done_o), 64'd0);
   endtask

   task automatic run_illegal(input string tag, input int addr);
      store_req_i  = 1'b1;
      store_addr_i = 3'(addr);
      tick();
      store_req_i  = 1'b0;
      check({tag, "_rd_en"}, 64'(reg_rd_en_o), 64'd1);
      check({tag, "_c1_valid"}, 64'(elem_valid_o), 64'd0);
      tick();
      check({tag, "_valid"}, 64'(elem_valid_o), 64'd0);
      check({tag, "_done"}, 64'(store_done_o), 64'd1);
      check({tag, "_err"}, 64'(store_err_o), 64'd1);
      check({tag, "_ready"}, 64'(store_ready_o), 64'd1);
      $display("%s done=%0b err=%0b", tag, store_done_o, store_err_o);
      tick();
      check({tag, "_done_1cyc"}, 64'(store_done_o), 64'd0);
      check({tag, "_err_1cyc"}, 64'(store_err_o), 64'd0);
      check({tag, "_valid2"}, 64'(elem_valid_o), 64'd0);
   endtask

   initial begin
      int n;
      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      store_req_i  = 1'b0;
      store_addr_i = '0;
      elem_ready_i = 1'b0;

      fl[0] = 32'h00000000; fl[1] = 32'h3f800000; fl[2] = 32'h40000000;
      fl[3] = 32'h40400000; fl[4] = 32'h40800000; fl[5] = 32'h40a00000;
      fl[6] = 32'h40c00000; fl[7] = 32'h40e00000; fl[8] = 32'h41000000;
      fl[9] = 32'h41100000;
      for (int r = 0; r < 8; r++) begin
         rf_data[r] = '0;
         rf_m[r]    = '0;
         rf_n[r]    = '0;
      end
      for (int k = 0; k < 9; k++) begin
         rf_data[5][k*FP +: FP] = fl[k+1];
         rf_data[2][k*FP +: FP] = fl[k];
         rf_data[3][k*FP +: FP] = fl[k+1];
      end
      rf_m[5] = 3'd3; rf_n[5] = 3'd3;
      rf_m[2] = 3'd2; rf_n[2] = 3'd3;
      rf_m[3] = 3'd0; rf_n[3] = 3'd3;
      rf_m[4] = 3'd3; rf_n[4] = 3'd0;
      rf_m[7] = 3'd4; rf_n[7] = 3'd3;
      rf_data[6][FP-1:0] = 32'hbf800000;
      rf_m[6] = 3'd1; rf_n[6] = 3'd1;

      // Reset state
      tick();
      tick();
      check("rst_ready", 64'(store_ready_o), 64'd1);
      check("rst_valid", 64'(elem_valid_o), 64'd0);
      check("rst_rd_en", 64'(reg_rd_en_o), 64'd0);
      check("rst_rd_addr", 64'(reg_rd_addr_o), 64'd0);
      check("rst_data", 64'(elem_data_o), 64'd0);
      check("rst_rowcol", 64'({elem_row_o, elem_col_o}), 64'd0);
      check("rst_last", 64'(elem_last_o), 64'd0);
      check("rst_done_err", 64'({store_done_o, store_err_o}), 64'd0);
      $display("reset: ready=%0b valid=%0b", store_ready_o, elem_valid_o);
      rst_n = 1'b1;
      tick();

      // Full 3x3
      run_store("full3x3", 5);

      // Backpressure: ready toggles every cycle starting low in cycle 2
      store_req_i  = 1'b1;
      store_addr_i = 3'd5;
      tick();
      store_req_i  = 1'b0;
      tick();
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 9; cyc++) begin
         elem_ready_i = (cyc % 2 == 1);
         #1;
         check("bp_valid", 64'(elem_valid_o), 64'd1);
         check("bp_data", 64'(elem_data_o), 64'(fl[n+1]));
         check("bp_row", 64'(elem_row_o), 64'(n / 3));
         check("bp_col", 64'(elem_col_o), 64'(n % 3));
         check("bp_last", 64'(elem_last_o), 64'(n == 8));
         check("bp_early_done", 64'(store_done_o), 64'd0);
         $display("bp cyc %0d ready=%0b data=%h", cyc, elem_ready_i, elem_data_o);
         if (elem_ready_i) n++;
         tick();
      end
      check("bp_count", 64'(n), 64'd9);
      check("bp_done", 64'(store_done_o), 64'd1);
      check("bp_end_valid", 64'(elem_valid_o), 64'd0);
      elem_ready_i = 1'b1;
      tick();

      // Partial 2x3
      run_store("part2x3", 2);

      // Illegal dimensions
      run_illegal("m0", 3);
      run_illegal("n0", 4);
      run_illegal("m4", 7);

      // Reset mid-stream after 4 transfers
      elem_ready_i = 1'b1;
      store_req_i  = 1'b1;
      store_addr_i = 3'd5;
      tick();
      store_req_i  = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("rm_data", 64'(elem_data_o), 64'(fl[k+1]));
         tick();
      end
      check("rm_pre_valid", 64'(elem_valid_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rm_async_valid", 64'(elem_valid_o), 64'd0);
      check("rm_ready", 64'(store_ready_o), 64'd1);
      check("rm_last", 64'(elem_last_o), 64'd0);
      check("rm_done", 64'(store_done_o), 64'd0);
      $display("reset mid-stream: valid=%0b ready=%0b", elem_valid_o, store_ready_o);
      tick();
      rst_n = 1'b1;
      check("rm_done_after", 64'(store_done_o), 64'd0);
      tick();
      check("rm_done_after2", 64'(store_done_o), 64'd0);
      run_store("post_rst", 5);

      // Request held high with a changing address during the stream
      elem_ready_i = 1'b1;
      store_req_i  = 1'b1;
      store_addr_i = 3'd5;
      tick();
      check("ign_rd_addr_c1", 64'(reg_rd_addr_o), 64'd5);
      store_addr_i = 3'd1;
      tick();
      for (int k = 0; k < 9; k++) begin
         store_addr_i = (k % 2 == 1) ? 3'd1 : 3'd6;
         #1;
         check("ign_rd_addr", 64'(reg_rd_addr_o), 64'd5);
         check("ign_data", 64'(elem_data_o), 64'(fl[k+1]));
         check("ign_rowcol", 64'({elem_row_o, elem_col_o}), 64'({2'(k / 3), 2'(k % 3)}));
         check("ign_valid", 64'(elem_valid_o), 64'd1);
         $display("ignreq elem %0d data=%h addr=%0d", k, elem_data_o, reg_rd_addr_o);
         if (k == 8) store_req_i = 1'b0;
         tick();
      end
      check("ign_done", 64'(store_done_o), 64'd1);
      tick();

      // 1x1 of -1.0
      run_store("one1x1", 6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
